// File: rtl/seven_segment_mux_pwm_pkg.sv
// Shared constants for the seven-segment display driver: hex glyph table
// (active-high, segment a on bit 0) and the all-dark cathode pattern.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/seven_segment_mux_pwm_if.sv
// Bundle between the status logic (master) and the display driver (slave).
interface seven_segment_mux_pwm_if #(
    parameter int NUM_DIGITS = 8,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] val_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic                    load_in;
    logic                    lz_en_in;
    logic [BRIGHT_W-1:0]     bright_in;
    logic [6:0]              cat_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_done_out;

    modport master (
        output val_in, dp_in, blank_in, load_in, lz_en_in, bright_in,
        input  cat_out, dp_out, an_out, frame_done_out
    );

    modport slave (
        input  val_in, dp_in, blank_in, load_in, lz_en_in, bright_in,
        output cat_out, dp_out, an_out, frame_done_out
    );
endinterface

// File: rtl/seven_segment_mux_pwm_hex_to_seg.sv
// Combinational hex nibble to active-high segment pattern lookup.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX_SEG_TABLE[nibble];
endmodule

// File: rtl/seven_segment_mux_pwm.sv
// Multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering, leading-zero suppression and PWM brightness.
module seven_segment_mux_pwm
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int COUNT_TO   = 100_000,
    parameter int BRIGHT_W   = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    seven_segment_mux_pwm_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (COUNT_TO > 0) ? $clog2(COUNT_TO + 1) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(COUNT_TO);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      slot_cnt_reg, slot_cnt_next;
    logic [IDX_W-1:0]      digit_idx_reg, digit_idx_next;
    logic [BRIGHT_W-1:0]   pwm_cnt_reg;
    logic [VAL_W-1:0]      active_val_reg, pend_val_reg;
    logic [NUM_DIGITS-1:0] active_dp_reg, pend_dp_reg;
    logic [NUM_DIGITS-1:0] active_blank_reg, pend_blank_reg;
    logic                  pend_flag_reg;
    logic [6:0]            cat_reg, cat_next;
    logic                  dp_reg, dp_next;
    logic [NUM_DIGITS-1:0] an_reg, an_next;
    logic                  frame_done_reg;

    logic                  slot_end;
    logic                  frame_end;
    logic                  an_on;
    logic [6:0]            digit_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] digit_dark;

    assign slot_end  = (slot_cnt_reg == SLOT_LAST);
    assign frame_end = slot_end && (digit_idx_reg == DIGIT_LAST);

    always_comb begin
        slot_cnt_next  = slot_cnt_reg + 1'b1;
        digit_idx_next = digit_idx_reg;
        if (slot_end) begin
            slot_cnt_next  = '0;
            digit_idx_next = frame_end ? '0 : digit_idx_reg + 1'b1;
        end
    end

    // Per-digit glyph and darkness, decoded from the active buffer only.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            hex_to_seg u_hex (
                .nibble (active_val_reg[4*gi +: 4]),
                .seg    (digit_seg[gi])
            );
            assign upper_zero[gi] = (active_val_reg[VAL_W-1:4*gi] == '0);
            assign digit_dark[gi] = active_blank_reg[gi]
                                  | (bus.lz_en_in && (gi != 0) && upper_zero[gi]);
        end
    endgenerate

    assign an_on = (bus.bright_in == '1) || (pwm_cnt_reg < bus.bright_in);

    always_comb begin
        an_next = '1;
        if (an_on) begin
            an_next[digit_idx_reg] = 1'b0;
        end
        if (digit_dark[digit_idx_reg]) begin
            cat_next = SEG_OFF;
            dp_next  = 1'b1;
        end else begin
            cat_next = ~digit_seg[digit_idx_reg];
            dp_next  = ~active_dp_reg[digit_idx_reg];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            slot_cnt_reg  <= '0;
            digit_idx_reg <= '0;
            pwm_cnt_reg   <= '0;
        end else begin
            slot_cnt_reg  <= slot_cnt_next;
            digit_idx_reg <= digit_idx_next;
            pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
        end
    end

    // A load landing on the boundary bypasses pending and goes live next frame.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            active_val_reg   <= '0;
            active_dp_reg    <= '0;
            active_blank_reg <= '0;
            pend_val_reg     <= '0;
            pend_dp_reg      <= '0;
            pend_blank_reg   <= '0;
            pend_flag_reg    <= 1'b0;
        end else if (frame_end) begin
            if (bus.load_in) begin
                active_val_reg   <= bus.val_in;
                active_dp_reg    <= bus.dp_in;
                active_blank_reg <= bus.blank_in;
            end else if (pend_flag_reg) begin
                active_val_reg   <= pend_val_reg;
                active_dp_reg    <= pend_dp_reg;
                active_blank_reg <= pend_blank_reg;
            end
            pend_flag_reg <= 1'b0;
        end else if (bus.load_in) begin
            pend_val_reg   <= bus.val_in;
            pend_dp_reg    <= bus.dp_in;
            pend_blank_reg <= bus.blank_in;
            pend_flag_reg  <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cat_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            cat_reg        <= cat_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
            frame_done_reg <= frame_end;
        end
    end

    assign bus.cat_out        = cat_reg;
    assign bus.dp_out         = dp_reg;
    assign bus.an_out         = an_reg;
    assign bus.frame_done_out = frame_done_reg;

endmodule
